expr_check_param: RTL and testbench
===================================

Name: expr_check_param

Overview:
- Streaming syntax checker for arithmetic expressions over ASCII characters, one character per accepted cycle.
- Grammar: expr := term (op term)*; term := number | '(' expr ')'; number := 1..MAX_DIGITS decimal digits; op := '+' | '*' (more with the optional feature).
- Generalises the single-digit, flat-expression recogniser: multi-digit operands, bounded parenthesis nesting, input qualifier, sticky error and depth visibility.
- Sits between a character source (UART/test stimulus) and control logic that samples the expression-valid flag.

Parameters:
- MAX_DEPTH, 7: maximum parenthesis nesting depth, 1..255.
- DEPTH_W, 3: width of the depth counter; must satisfy 2^DEPTH_W > MAX_DEPTH.
- MAX_DIGITS, 4: maximum digits per number, 1..15; 1 gives the legacy single-digit grammar.

Ports:
- clk  in  1  clock, rising edge.
- clr  in  1  reset, asynchronous, active-high; returns the block to START.
- in_valid  in  1  qualifies in; when low, no state changes.
- in  in  8  ASCII character.
- out  out  1  1 when the consumed prefix is a complete valid expression.
- err  out  1  sticky syntax error flag.
- depth  out  DEPTH_W  current open-parenthesis count.

Behaviour:
- Reset (clr=1, async): state=START, depth=0, digit count=0, out=0, err=0.
- Character classes: digit = 48..57; '(' = 40; ')' = 41; op = 42 or 43; anything else is illegal.
- Registered FSM states: START (expecting a term), NUM (inside a number), CLOSE (just after ')'), ERR. A 2-bit encoding is sufficient.
- Every transition occurs only on a clk edge with in_valid=1. With in_valid=0, state, depth and digit count hold.
- START:
  - digit -> NUM, dcnt=1.
  - '(' with depth<MAX_DEPTH -> START, depth+1.
  - '(' with depth==MAX_DEPTH -> ERR.
  - anything else -> ERR.
- NUM:
  - digit with dcnt<MAX_DIGITS -> NUM, dcnt+1.
  - digit with dcnt==MAX_DIGITS -> ERR.
  - op -> START, dcnt=0.
  - ')' with depth>0 -> CLOSE, depth-1.
  - ')' with depth==0 -> ERR.
  - anything else -> ERR.
- CLOSE:
  - op -> START.
  - ')' with depth>0 -> CLOSE, depth-1.
  - ')' with depth==0 -> ERR.
  - digit, '(' or illegal -> ERR.
- ERR: absorbing until clr. depth and dcnt freeze at their values on entry.
- out = (state==NUM || state==CLOSE) && depth==0. It is combinational from registered state, so it reflects a character one cycle after that character is accepted.
- err = (state==ERR), combinational from state; out=0 whenever err=1.
- No arithmetic on values. Counters never wrap, because every overflow and underflow case routes to ERR before the counter changes.
- clr asserted mid-expression discards everything; the next accepted character starts a fresh expression.

Optional Feature:
- Macro EXPR_SUB_DIV_EN.
- Defined: '-' (45) and '/' (47) join the op class with identical transitions to '+' and '*'.
- Undefined: 45 and 47 are illegal characters and drive the FSM to ERR.

Test Plan:
- Stream "12+3*45" with in_valid=1 every cycle: out=1 after '2', 0 after '+', 1 after '3', 0 after '*', 1 after '4' and '5'; err stays 0; depth stays 0.
- Stream "(1+(2))*3": depth sequence 1,1,1,2,2,1,0,0,0; out=1 only after the first ')'-to-depth-0 and after the final '3'.
- Stream "12345" with MAX_DIGITS=4: after the fifth digit err=1 and out=0; a following "+1" leaves err=1.
- Stream eight '(' with MAX_DEPTH=7: depth reaches 7, the eighth '(' sets err=1, depth holds at 7. A separate run of ")" from START also gives err=1.
- Stream "1+2" with in_valid toggling 1,0,1,0,1: results match the continuous stream, and state holds during the in_valid=0 cycles. Assert clr mid-stream: out=0, err=0, depth=0 immediately, without waiting for a clock edge.
- Stream "7-2": with EXPR_SUB_DIV_EN defined, out=1 at the end; without it, err=1 after '-'.

Source files
------------

// File: rtl/expr_check_param_if.sv
`default_nettype none
// ============================================================================
//  Module   : expr_check_param_if
//  Purpose  : Character stream and status bundle for the expression checker.
//             master = character source / status consumer,
//             slave  = the checker itself.
//  Revision : 1.0  initial release
// ============================================================================
interface expr_check_param_if #(
  parameter int DEPTH_W = 3
);
  logic               in_valid;
  logic [7:0]         in;
  logic               out;
  logic               err;
  logic [DEPTH_W-1:0] depth;

  modport master (
    output in_valid,
    output in,
    input  out,
    input  err,
    input  depth
  );

  modport slave (
    input  in_valid,
    input  in,
    output out,
    output err,
    output depth
  );
endinterface
`default_nettype wire

// File: rtl/expr_check_param.sv
`default_nettype none
// ============================================================================
//  Module   : expr_check_param
//  Purpose  : Streaming syntax checker for ASCII arithmetic expressions.
//             expr := term (op term)*, term := number | '(' expr ')',
//             number := 1..MAX_DIGITS digits, op := '+' | '*'.
//             Optional macro EXPR_SUB_DIV_EN adds '-' and '/' as operators.
//  Revision : 1.0  initial release
// ============================================================================
module expr_check_param #(
  parameter int MAX_DEPTH  = 7,
  parameter int DEPTH_W    = 3,
  parameter int MAX_DIGITS = 4
) (
  input  logic                   clk,
  input  logic                   clr,
  expr_check_param_if.slave      bus
);

  localparam logic [DEPTH_W-1:0] c_max_depth  = DEPTH_W'(MAX_DEPTH);
  localparam logic [DEPTH_W-1:0] c_depth_one  = DEPTH_W'(1);
  localparam logic [DEPTH_W-1:0] c_depth_zero = '0;
  localparam logic [3:0]         c_max_digits = 4'(MAX_DIGITS);

  typedef enum logic [1:0] {
    ST_START = 2'd0,   // expecting a term
    ST_NUM   = 2'd1,   // inside a number
    ST_CLOSE = 2'd2,   // just consumed ')'
    ST_ERR   = 2'd3    // absorbing error
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [DEPTH_W-1:0] r_depth, w_depth_nxt;
  logic [3:0]         r_dcnt,  w_dcnt_nxt;

  logic w_is_digit;
  logic w_is_lpar;
  logic w_is_rpar;
  logic w_is_op;

  // Character classification of the incoming byte
  assign w_is_digit = (bus.in >= 8'd48) && (bus.in <= 8'd57);
  assign w_is_lpar  = (bus.in == 8'd40);
  assign w_is_rpar  = (bus.in == 8'd41);
`ifdef EXPR_SUB_DIV_EN
  assign w_is_op    = (bus.in == 8'd42) || (bus.in == 8'd43) ||
                      (bus.in == 8'd45) || (bus.in == 8'd47);
`else
  assign w_is_op    = (bus.in == 8'd42) || (bus.in == 8'd43);
`endif

  // Next-state logic; overflow/underflow cases go to ERR before any counter moves
  always_comb begin
    w_state_nxt = r_state;
    w_depth_nxt = r_depth;
    w_dcnt_nxt  = r_dcnt;
    if (bus.in_valid) begin
      case (r_state)
        ST_START: begin
          if (w_is_digit) begin
            w_state_nxt = ST_NUM;
            w_dcnt_nxt  = 4'd1;
          end else if (w_is_lpar && (r_depth < c_max_depth)) begin
            w_depth_nxt = r_depth + c_depth_one;
          end else begin
            w_state_nxt = ST_ERR;
          end
        end
        ST_NUM: begin
          if (w_is_digit) begin
            if (r_dcnt < c_max_digits) w_dcnt_nxt  = r_dcnt + 4'd1;
            else                       w_state_nxt = ST_ERR;
          end else if (w_is_op) begin
            w_state_nxt = ST_START;
            w_dcnt_nxt  = 4'd0;
          end else if (w_is_rpar && (r_depth != c_depth_zero)) begin
            w_state_nxt = ST_CLOSE;
            w_depth_nxt = r_depth - c_depth_one;
          end else begin
            w_state_nxt = ST_ERR;
          end
        end
        ST_CLOSE: begin
          if (w_is_op) begin
            w_state_nxt = ST_START;
          end else if (w_is_rpar && (r_depth != c_depth_zero)) begin
            w_depth_nxt = r_depth - c_depth_one;
          end else begin
            w_state_nxt = ST_ERR;
          end
        end
        default: begin
          // ERR absorbs everything; counters stay frozen
          w_state_nxt = ST_ERR;
        end
      endcase
    end
  end

  // State and counter registers with asynchronous clear
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= ST_START;
      r_depth <= '0;
      r_dcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_depth <= w_depth_nxt;
      r_dcnt  <= w_dcnt_nxt;
    end
  end

  // Status outputs decoded from registered state
  assign bus.out   = ((r_state == ST_NUM) || (r_state == ST_CLOSE)) &&
                     (r_depth == c_depth_zero);
  assign bus.err   = (r_state == ST_ERR);
  assign bus.depth = r_depth;

endmodule
`default_nettype wire

// File: tb/tb_expr_check_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_expr_check_param
//  Purpose  : Self-checking bench for expr_check_param. A prefix-rescanning
//             grammar model is compared every cycle, and hand-computed
//             literal expectations pin the model on the directed streams.
//  Revision : 1.0  initial release
// ============================================================================
module tb_expr_check_param;

  localparam int MAX_DEPTH  = 7;
  localparam int DEPTH_W    = 3;
  localparam int MAX_DIGITS = 4;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  expr_check_param_if #(.DEPTH_W(DEPTH_W)) bus ();

  expr_check_param #(
    .MAX_DEPTH (MAX_DEPTH),
    .DEPTH_W   (DEPTH_W),
    .MAX_DIGITS(MAX_DIGITS)
  ) dut (
    .clk(clk),
    .clr(clr),
    .bus(bus)
  );

  int n_vec = 0;
  int n_bad = 0;
  logic started = 1'b0;
  byte unsigned acc_q[$];

  // Record every accepted character since the last clear
  always @(posedge clk or posedge clr) begin
    if (clr) acc_q.delete();
    else if (bus.in_valid) acc_q.push_back(bus.in);
  end

  // 0 illegal, 1 digit, 2 '(', 3 ')', 4 operator
  function automatic int cls_of(byte unsigned c);
    if (c >= 8'd48 && c <= 8'd57) return 1;
    if (c == 8'd40) return 2;
    if (c == 8'd41) return 3;
    if (c == 8'd42 || c == 8'd43) return 4;
`ifdef EXPR_SUB_DIV_EN
    if (c == 8'd45 || c == 8'd47) return 4;
`endif
    return 0;
  endfunction

  // Rescan the whole accepted prefix against the grammar rules
  function automatic void model(output logic e_out, output logic e_err, output int e_depth);
    int depth = 0;
    int run   = 0;
    int prev  = 0;
    logic bad = 1'b0;
    foreach (acc_q[i]) begin
      int cls;
      if (bad) break;
      cls = cls_of(acc_q[i]);
      case (cls)
        1: if (prev == 3 || run == MAX_DIGITS) bad = 1'b1; else run++;
        2: if (!(prev == 0 || prev == 2 || prev == 4) || depth == MAX_DEPTH) bad = 1'b1;
           else depth++;
        3: if (!(prev == 1 || prev == 3) || depth == 0) bad = 1'b1; else depth--;
        4: if (!(prev == 1 || prev == 3)) bad = 1'b1;
        default: bad = 1'b1;
      endcase
      if (!bad) begin
        if (cls != 1) run = 0;
        prev = cls;
      end
    end
    e_err   = bad;
    e_depth = depth;
    e_out   = !bad && (prev == 1 || prev == 3) && (depth == 0);
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, got, exp);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    logic m_out, m_err;
    int   m_depth;
    if (started && !clr) begin
      model(m_out, m_err, m_depth);
      chk("model_out",   32'(bus.out),   32'(m_out));
      chk("model_err",   32'(bus.err),   32'(m_err));
      chk("model_depth", 32'(bus.depth), m_depth);
    end
  end

  task automatic send(byte unsigned c);
    bus.in_valid = 1'b1;
    bus.in       = c;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in       = 8'd40;
  endtask

  task automatic send_str(string s);
    foreach (s[i]) send(s[i]);
  endtask

  // Idle cycle with '(' on the bus so an ignored qualifier would be visible
  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in       = 8'd40;
    @(posedge clk);
    #1;
  endtask

  // Asynchronous clear: outputs must drop before any clock edge
  task automatic do_clr();
    clr = 1'b1;
    #1;
    chk("clr_out",   32'(bus.out),   32'd0);
    chk("clr_err",   32'(bus.err),   32'd0);
    chk("clr_depth", 32'(bus.depth), 32'd0);
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  string extra [9] = '{"((12*3)+4)", "1+(", "(1)2", "1++2", "9999+1",
                       "()", "1 ", "(((((((1)))))))", "1))"};

  initial begin
    clr          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in       = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out",   32'(bus.out),   32'd0);
    chk("rst_err",   32'(bus.err),   32'd0);
    chk("rst_depth", 32'(bus.depth), 32'd0);
    clr     = 1'b0;
    started = 1'b1;

    // "12+3*45"
    send("1"); send("2"); chk("s1_out_2", 32'(bus.out), 32'd1);
    send("+");            chk("s1_out_plus", 32'(bus.out), 32'd0);
    send("3");            chk("s1_out_3", 32'(bus.out), 32'd1);
    send("*");            chk("s1_out_mul", 32'(bus.out), 32'd0);
    send("4");            chk("s1_out_4", 32'(bus.out), 32'd1);
    send("5");            chk("s1_out_5", 32'(bus.out), 32'd1);
    chk("s1_err", 32'(bus.err), 32'd0);
    chk("s1_depth", 32'(bus.depth), 32'd0);

    // "(1+(2))*3"
    do_clr();
    send("(");  chk("s2_d1", 32'(bus.depth), 32'd1);
    send("1");  send("+");
    send("(");  chk("s2_d4", 32'(bus.depth), 32'd2);
    send("2");  chk("s2_out_2", 32'(bus.out), 32'd0);
    send(")");  chk("s2_d6", 32'(bus.depth), 32'd1); chk("s2_out_6", 32'(bus.out), 32'd0);
    send(")");  chk("s2_d7", 32'(bus.depth), 32'd0); chk("s2_out_7", 32'(bus.out), 32'd1);
    send("*");  chk("s2_out_mul", 32'(bus.out), 32'd0);
    send("3");  chk("s2_out_3", 32'(bus.out), 32'd1);

    // "12345" overflows the digit count
    do_clr();
    send_str("1234"); chk("s3_out_4dig", 32'(bus.out), 32'd1);
    send("5");        chk("s3_err_5", 32'(bus.err), 32'd1); chk("s3_out_5", 32'(bus.out), 32'd0);
    send_str("+1");   chk("s3_err_sticky", 32'(bus.err), 32'd1); chk("s3_out_sticky", 32'(bus.out), 32'd0);

    // eight '(' overflow the depth
    do_clr();
    repeat (7) send("(");
    chk("s4_depth7", 32'(bus.depth), 32'd7); chk("s4_err7", 32'(bus.err), 32'd0);
    send("(");
    chk("s4_err8", 32'(bus.err), 32'd1); chk("s4_depth_hold", 32'(bus.depth), 32'd7);

    // ')' from START underflows
    do_clr();
    send(")");
    chk("s5_err", 32'(bus.err), 32'd1); chk("s5_depth", 32'(bus.depth), 32'd0);

    // "1+2" with in_valid gaps
    do_clr();
    send("1"); chk("s6_out_1", 32'(bus.out), 32'd1);
    idle();    chk("s6_out_hold1", 32'(bus.out), 32'd1); chk("s6_depth_hold", 32'(bus.depth), 32'd0);
    send("+"); chk("s6_out_plus", 32'(bus.out), 32'd0);
    idle();    chk("s6_out_hold2", 32'(bus.out), 32'd0); chk("s6_err_hold", 32'(bus.err), 32'd0);
    send("2"); chk("s6_out_2", 32'(bus.out), 32'd1);

    // clr mid-expression
    send_str("*(3");
    chk("s7_depth", 32'(bus.depth), 32'd1); chk("s7_out", 32'(bus.out), 32'd0);
    do_clr();

    // "7-2"
    send("7"); send("-");
`ifdef EXPR_SUB_DIV_EN
    send("2");
    chk("s8_out", 32'(bus.out), 32'd1); chk("s8_err", 32'(bus.err), 32'd0);
`else
    chk("s8_err_minus", 32'(bus.err), 32'd1);
    send("2");
    chk("s8_err", 32'(bus.err), 32'd1); chk("s8_out", 32'(bus.out), 32'd0);
`endif

    // further streams checked by the model alone
    foreach (extra[k]) begin
      do_clr();
      send_str(extra[k]);
      idle();
    end

    idle();
    idle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
